// File: rtl/wb_stage_if.sv
// Bus between mem_stage (master side) and the writeback stage (slave side),
// including the accelerator done/result lines and the register-file write port.
interface wb_stage_if #(
    parameter int DATA_W = 19,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              valid_in;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus1;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic              fft_strt;
    logic              crypto_en;
    logic              fft_done;
    logic [DATA_W-1:0] fft_result;
    logic              crypto_done;
    logic [DATA_W-1:0] crypto_result;
    logic              err_clr;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_out;
    logic              acc_err;
    logic [CNT_W-1:0]  retire_cnt;

    // Handshake: an instruction transfers on a rising edge where valid_in=1
    // and stall_out=0; while stall_out=1 upstream holds and valid_in is ignored.
    modport master (
        output valid_in, alu_result, read_data, pc_plus1, rd_addr, reg_write,
               wb_sel, fft_strt, crypto_en, fft_done, fft_result, crypto_done,
               crypto_result, err_clr,
        input  rf_we, rf_waddr, rf_wdata, stall_out, acc_err, retire_cnt
    );

    modport slave (
        input  valid_in, alu_result, read_data, pc_plus1, rd_addr, reg_write,
               wb_sel, fft_strt, crypto_en, fft_done, fft_result, crypto_done,
               crypto_result, err_clr,
        output rf_we, rf_waddr, rf_wdata, stall_out, acc_err, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback source select, and a stall FSM
// that waits (bounded by TIMEOUT) for the FFT or crypto accelerator result.
module wb_stage #(
    parameter int DATA_W  = 19,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_FFT    = 2'd1,
        WAIT_CRYPTO = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              err_set;
    logic              rw_nz;
    logic [DATA_W-1:0] sel_data;

    assign rw_nz = bus.reg_write && (bus.rd_addr != '0);

    always_comb begin
        sel_data = '0;
        case (bus.wb_sel)
            2'd0:    sel_data = bus.alu_result;
            2'd1:    sel_data = bus.read_data;
            2'd2:    sel_data = bus.pc_plus1;
            default: sel_data = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        retire_d = retire_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    waddr_d = bus.rd_addr;
                    rw_d    = rw_nz;
                    cnt_d   = '0;
                    if (bus.fft_strt) begin
                        state_d = WAIT_FFT;
                        err_set = bus.crypto_en;
                    end else if (bus.crypto_en) begin
                        state_d = WAIT_CRYPTO;
                    end else begin
                        we_d     = rw_nz;
                        wdata_d  = sel_data;
                        retire_d = retire_q + CNT_W'(1);
                    end
                end
            end
            WAIT_FFT, WAIT_CRYPTO: begin
                cnt_d = cnt_q + CW'(1);
                // A matching done in the expiry cycle still completes normally.
                if ((state_q == WAIT_FFT) ? bus.fft_done : bus.crypto_done) begin
                    state_d  = IDLE;
                    we_d     = rw_q;
                    wdata_d  = (state_q == WAIT_FFT) ? bus.fft_result : bus.crypto_result;
                    retire_d = retire_q + CNT_W'(1);
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    err_set  = 1'b1;
                    retire_d = retire_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            err_q    <= err_d;
            retire_q <= retire_d;
        end
    end

    assign bus.rf_we      = we_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.stall_out  = (state_q != IDLE);
    assign bus.acc_err    = err_q;
    assign bus.retire_cnt = retire_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with TIMEOUT=8; expected values are hand-computed.
module tb_wb_stage;
    localparam int DATA_W  = 19;
    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_o;
    int         passed;
    int         total;
    int         stall_cycles;

    wb_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    wb_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.valid_in      = 1'b0;
        bus.alu_result    = '0;
        bus.read_data     = '0;
        bus.pc_plus1      = '0;
        bus.rd_addr       = '0;
        bus.reg_write     = 1'b0;
        bus.wb_sel        = 2'd0;
        bus.fft_strt      = 1'b0;
        bus.crypto_en     = 1'b0;
        bus.fft_done      = 1'b0;
        bus.fft_result    = '0;
        bus.crypto_done   = 1'b0;
        bus.crypto_result = '0;
        bus.err_clr       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},     32'(bus.rf_we), 0);
        chk({tag, "_waddr"},  32'(bus.rf_waddr), 0);
        chk({tag, "_wdata"},  32'(bus.rf_wdata), 0);
        chk({tag, "_stall"},  32'(bus.stall_out), 0);
        chk({tag, "_err"},    32'(bus.acc_err), 0);
        chk({tag, "_retire"}, 32'(bus.retire_cnt), 0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        chk_all_zero("reset");
        chk("reset_state", 32'(state_o), 0);
        rst_n = 1'b1;
        step();

        // ALU writeback
        bus.valid_in = 1'b1; bus.wb_sel = 2'd0; bus.alu_result = 19'd123;
        bus.rd_addr = 5'd5; bus.reg_write = 1'b1;
        step();
        bus.valid_in = 1'b0;
        chk("alu_we", 32'(bus.rf_we), 1);
        chk("alu_waddr", 32'(bus.rf_waddr), 5);
        chk("alu_wdata", 32'(bus.rf_wdata), 123);
        chk("alu_retire", 32'(bus.retire_cnt), 1);
        chk("alu_stall", 32'(bus.stall_out), 0);
        step();
        chk("idle_we", 32'(bus.rf_we), 0);

        // Load then link, back-to-back
        bus.valid_in = 1'b1; bus.wb_sel = 2'd1; bus.read_data = 19'h7F000; bus.rd_addr = 5'd3;
        step();
        chk("ld_we", 32'(bus.rf_we), 1);
        chk("ld_waddr", 32'(bus.rf_waddr), 3);
        chk("ld_wdata", 32'(bus.rf_wdata), 32'h7F000);
        chk("ld_stall", 32'(bus.stall_out), 0);
        bus.wb_sel = 2'd2; bus.pc_plus1 = 19'd42; bus.rd_addr = 5'd1;
        step();
        bus.valid_in = 1'b0;
        chk("lnk_we", 32'(bus.rf_we), 1);
        chk("lnk_waddr", 32'(bus.rf_waddr), 1);
        chk("lnk_wdata", 32'(bus.rf_wdata), 42);
        chk("lnk_stall", 32'(bus.stall_out), 0);
        step();
        chk("lnk_retire", 32'(bus.retire_cnt), 3);
        chk("lnk_we_drop", 32'(bus.rf_we), 0);

        // FFT op: done arrives in the fourth stall cycle
        bus.valid_in = 1'b1; bus.fft_strt = 1'b1; bus.wb_sel = 2'd3;
        bus.rd_addr = 5'd7; bus.reg_write = 1'b1;
        step();
        clear_inputs();
        bus.reg_write = 1'b1;
        chk("fft_state", 32'(state_o), 1);
        chk("fft_issue_we", 32'(bus.rf_we), 0);
        chk("fft_issue_retire", 32'(bus.retire_cnt), 3);
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.stall_out) stall_cycles++;
            if (i == 3) begin
                bus.fft_done = 1'b1; bus.fft_result = 19'd138;
            end
            step();
        end
        bus.fft_done = 1'b0;
        chk("fft_stall_cycles", 32'(stall_cycles), 4);
        chk("fft_we", 32'(bus.rf_we), 1);
        chk("fft_waddr", 32'(bus.rf_waddr), 7);
        chk("fft_wdata", 32'(bus.rf_wdata), 138);
        chk("fft_stall", 32'(bus.stall_out), 0);
        chk("fft_retire", 32'(bus.retire_cnt), 4);
        chk("fft_err", 32'(bus.acc_err), 0);

        // Crypto timeout with a stray fft_done mid-wait
        bus.valid_in = 1'b1; bus.crypto_en = 1'b1; bus.wb_sel = 2'd3; bus.rd_addr = 5'd9;
        step();
        clear_inputs();
        chk("cry_state", 32'(state_o), 2);
        stall_cycles = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bus.stall_out) stall_cycles++;
            chk("cry_wait_we", 32'(bus.rf_we), 0);
            bus.fft_done = (i == 3);
            bus.fft_result = 19'd77;
            step();
        end
        bus.fft_done = 1'b0;
        chk("cry_stall_cycles", 32'(stall_cycles), TIMEOUT);
        chk("cry_to_stall", 32'(bus.stall_out), 0);
        chk("cry_to_we", 32'(bus.rf_we), 0);
        chk("cry_to_err", 32'(bus.acc_err), 1);
        chk("cry_to_retire", 32'(bus.retire_cnt), 5);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("err_clr", 32'(bus.acc_err), 0);

        // Stray done while idle
        bus.fft_done = 1'b1; bus.crypto_done = 1'b1;
        step();
        bus.fft_done = 1'b0; bus.crypto_done = 1'b0;
        chk("idle_done_we", 32'(bus.rf_we), 0);
        chk("idle_done_retire", 32'(bus.retire_cnt), 5);

        // rd=0 never writes, but still retires
        bus.valid_in = 1'b1; bus.wb_sel = 2'd0; bus.alu_result = 19'd55;
        bus.rd_addr = 5'd0; bus.reg_write = 1'b1;
        step();
        bus.valid_in = 1'b0;
        chk("x0_we", 32'(bus.rf_we), 0);
        chk("x0_retire", 32'(bus.retire_cnt), 6);

        // Both accelerator flags, with err_clr in the same cycle: set wins
        bus.valid_in = 1'b1; bus.fft_strt = 1'b1; bus.crypto_en = 1'b1;
        bus.rd_addr = 5'd4; bus.err_clr = 1'b1;
        step();
        clear_inputs();
        chk("both_state", 32'(state_o), 1);
        chk("both_stall", 32'(bus.stall_out), 1);
        chk("both_err", 32'(bus.acc_err), 1);
        bus.crypto_done = 1'b1; bus.crypto_result = 19'd99;
        step();
        bus.crypto_done = 1'b0;
        chk("both_wrong_done_stall", 32'(bus.stall_out), 1);
        chk("both_wrong_done_we", 32'(bus.rf_we), 0);

        // Asynchronous reset while in WAIT_FFT
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_state", 32'(state_o), 0);
        step();
        rst_n = 1'b1;
        bus.fft_done = 1'b1; bus.fft_result = 19'd500;
        step();
        bus.fft_done = 1'b0;
        chk("post_rst_we", 32'(bus.rf_we), 0);
        chk("post_rst_stall", 32'(bus.stall_out), 0);
        chk("post_rst_retire", 32'(bus.retire_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
